// File: rtl/spi_pkg.sv
// Shared types for the SPI master shift engine.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CS_SETUP,
      XFER,
      CS_HOLD
   } spi_state_e;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam int unsigned SPI_DATA_W_DEF = 8;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: free-running 0..CLK_DIV-1 while enabled, tick on the last count.
module spi_clk_div #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i & (cnt_q == CNT_MAX);

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: all four modes, MSB first, CS setup/hold of one SCLK half-period each.
module spi_shift_engine
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W  = SPI_DATA_W_DEF,
   parameter int unsigned CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              done,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs_n
);

   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("spi_shift_engine: CLK_DIV must be >= 2");
   end
   if ((DATA_W < 2) || (DATA_W > 32)) begin : g_bad_data_w
      $error("spi_shift_engine: DATA_W must be in 2..32");
   end

   localparam int unsigned EDGE_W = $clog2(2 * DATA_W);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

   spi_state_e        state_q, state_d;
   spi_mode_t         mode_q, mode_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [EDGE_W-1:0] edge_q, edge_d;
   logic              start_q;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              cs_n_q, cs_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              tick;
   logic              accept;
   logic              leading;
   logic              last_edge;

   spi_clk_div #(
      .CLK_DIV(CLK_DIV)
   ) u_clk_div (
      .clk   (clk),
      .rst   (rst),
      .en_i  (state_q != IDLE),
      .clr_i (state_q == IDLE),
      .tick_o(tick)
   );

   assign accept    = start & ~start_q & (state_q == IDLE);
   assign leading   = ~edge_q[0];
   assign last_edge = (edge_q == LAST_EDGE);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      sh_d    = sh_q;
      rx_d    = rx_q;
      edge_d  = edge_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;
      busy_d  = busy_q;
      done_d  = done_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = CS_SETUP;
               mode_d  = spi_mode_t'(mode);
               sh_d    = tx_data;
               sclk_d  = mode[1];
               mosi_d  = mode[0] ? 1'b0 : tx_data[DATA_W-1];
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         CS_SETUP: begin
            if (tick) begin
               state_d = XFER;
               edge_d  = '0;
            end
         end
         XFER: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               edge_d = edge_q + EDGE_W'(1);
               // Sampling shifts miso into the LSB, so sh[MSB] is always the next bit to drive.
               if (!mode_q.cpha) begin
                  if (leading) begin
                     sh_d = {sh_q[DATA_W-2:0], miso};
                  end else if (!last_edge) begin
                     mosi_d = sh_q[DATA_W-1];
                  end
               end else begin
                  if (leading) begin
                     mosi_d = sh_q[DATA_W-1];
                  end else begin
                     sh_d = {sh_q[DATA_W-2:0], miso};
                  end
               end
               if (last_edge) begin
                  state_d = CS_HOLD;
                  rx_d    = sh_d;
               end
            end
         end
         CS_HOLD: begin
            if (tick) begin
               state_d = IDLE;
               sclk_d  = mode_q.cpol;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= '0;
         sh_q    <= '0;
         rx_q    <= '0;
         edge_q  <= '0;
         start_q <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         sh_q    <= sh_d;
         rx_q    <= rx_d;
         edge_q  <= edge_d;
         start_q <= start;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign rx_data = rx_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with a mode-aware SPI slave model.
module tb_spi_shift_engine;

   localparam int unsigned DW = 8;
   localparam int unsigned CD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    mode;
   logic [DW-1:0] tx_data;
   logic [DW-1:0] rx_data;
   logic          busy;
   logic          done;
   logic          sclk;
   logic          mosi;
   logic          miso;
   logic          cs_n;

   int total = 0;
   int bad   = 0;

   logic          loop_en;
   logic          cpol_tb;
   logic          cpha_tb;
   logic          miso_s;
   logic [DW-1:0] s_tx;
   logic [DW-1:0] s_rx;
   int            lead  = 0;
   int            trail = 0;
   int            rises = 0;

   always #5 clk = ~clk;

   spi_shift_engine #(
      .DATA_W (DW),
      .CLK_DIV(CD)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mode   (mode),
      .tx_data(tx_data),
      .rx_data(rx_data),
      .busy   (busy),
      .done   (done),
      .sclk   (sclk),
      .mosi   (mosi),
      .miso   (miso),
      .cs_n   (cs_n)
   );

   assign miso = loop_en ? mosi : miso_s;

   // Slave: leading edge moves sclk away from CPOL; it captures mosi on the same edge the master samples miso.
   always @(negedge cs_n) begin
      lead   = 0;
      trail  = 0;
      s_rx   = '0;
      miso_s = cpha_tb ? 1'b0 : s_tx[DW-1];
   end

   always @(posedge cs_n) begin
      lead  = 0;
      trail = 0;
   end

   always @(sclk) begin
      if (cs_n === 1'b0) begin
         if (sclk !== cpol_tb) begin
            if (lead < DW) begin
               lead++;
               if (!cpha_tb) s_rx = {s_rx[DW-2:0], mosi};
               else          miso_s = s_tx[DW-lead];
            end
         end else if (lead > trail) begin
            trail++;
            if (!cpha_tb) begin
               if (trail < DW) miso_s = s_tx[DW-1-trail];
            end else begin
               s_rx = {s_rx[DW-2:0], mosi};
            end
         end
      end
   end

   always @(posedge sclk) rises++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setup(input logic [1:0] m, input logic [DW-1:0] tx, input logic [DW-1:0] sd,
                        input logic lp);
      mode    = m;
      tx_data = tx;
      s_tx    = sd;
      loop_en = lp;
      cpol_tb = m[1];
      cpha_tb = m[0];
   endtask

   task automatic run_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic do_xfer(input string tag, input logic [1:0] m, input logic [DW-1:0] tx,
                          input logic [DW-1:0] sd, input logic lp, input logic [DW-1:0] exp_rx);
      int n;
      setup(m, tx, sd, lp);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      chk({tag, "_busy_on"},   busy, 1);
      chk({tag, "_cs_low"},    cs_n, 0);
      chk({tag, "_sclk_idle"}, sclk, m[1]);
      chk({tag, "_mosi_first"}, mosi, m[0] ? 1'b0 : tx[DW-1]);
      run_busy(n);
      chk({tag, "_busy_len"},  n, 72);
      chk({tag, "_done"},      done, 1);
      chk({tag, "_cs_high"},   cs_n, 1);
      chk({tag, "_sclk_end"},  sclk, m[1]);
      chk({tag, "_rx"},        rx_data, exp_rx);
      chk({tag, "_mosi_bits"}, s_rx, tx);
      start = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int extra;
      rst     = 1'b1;
      start   = 1'b0;
      mode    = 2'b00;
      tx_data = '0;
      loop_en = 1'b0;
      cpol_tb = 1'b0;
      cpha_tb = 1'b0;
      s_tx    = '0;
      miso_s  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sclk", sclk, 0);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_mosi", mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rx",   rx_data, 0);
      rst = 1'b0;
      @(negedge clk);

      rises = 0;
      do_xfer("m0_loop", 2'b00, 8'hA5, 8'h00, 1'b1, 8'hA5);
      chk("m0_rises", rises, 8);

      do_xfer("m3", 2'b11, 8'h0F, 8'h3C, 1'b0, 8'h3C);
      do_xfer("m1", 2'b01, 8'h5A, 8'h81, 1'b0, 8'h81);
      do_xfer("m2", 2'b10, 8'hC6, 8'h81, 1'b0, 8'h81);

      // start held high across completion
      setup(2'b00, 8'h33, 8'h99, 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      chk("held_busy_on", busy, 1);
      run_busy(n);
      chk("held_busy_len", n, 72);
      chk("held_rx", rx_data, 8'h99);
      extra = 0;
      repeat (130) begin
         @(negedge clk);
         if (busy === 1'b1) extra++;
      end
      chk("held_no_retrigger", extra, 0);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      chk("rearm_busy", busy, 1);
      chk("rearm_done_clr", done, 0);
      run_busy(n);
      chk("rearm_busy_len", n, 72);
      chk("rearm_done", done, 1);

      // second start edge and tx/mode change mid-transfer are ignored
      start = 1'b0;
      setup(2'b00, 8'h96, 8'h55, 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      repeat (4) @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1;
      repeat (2) @(negedge clk);
      tx_data = 8'hFF;
      mode    = 2'b11;
      run_busy(n);
      chk("ign_done", done, 1);
      chk("ign_rx", rx_data, 8'h55);
      chk("ign_mosi_bits", s_rx, 8'h96);
      extra = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy === 1'b1) extra++;
      end
      chk("ign_no_queue", extra, 0);
      start = 1'b0;

      // reset in the middle of XFER
      setup(2'b00, 8'h3C, 8'hAA, 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      repeat (26) @(negedge clk);
      chk("abort_pre_busy", busy, 1);
      chk("abort_pre_rx", rx_data, 8'h55);
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk("abort_cs_n", cs_n, 1);
      chk("abort_sclk", sclk, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_rx",   rx_data, 0);
      chk("abort_mosi", mosi, 0);
      rst = 1'b0;
      @(negedge clk);

      do_xfer("post_rst", 2'b00, 8'h3C, 8'hC3, 1'b0, 8'hC3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
